// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares one AXI read address/data channel pair between two cache-style read
// requesters (port 0 = icache refill, port 1 = dcache refill/uncached load).
// One AR request is latched at a time and tagged with arid = port index. R
// beats are steered back by rid[0]. Each port can have at most one read in
// flight. A read whose word address matches the pending write is held off
// until the write path reports the write as acked.
//
// Optional build macro:
//   RD_ARB_RR_EN  - round-robin arbitration between the two ports (a 1-bit
//                   last-grant register). When undefined, port 1 always wins
//                   on contention.
//
// Ports:
//   aclk, areset           clock, asynchronous active-high reset
//   rd_req[1:0]            per-port read request
//   rd_type0/1             3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 line
//   rd_addr0/1             request address
//   rd_rdy[1:0]            request accepted this cycle (rd_req & rd_rdy)
//   ret_valid/ret_last     per-port return beat valid / final beat
//   ret_data               shared return data, qualified by ret_valid
//   wr_pending, wr_addr    outstanding write used for the RAW hazard check
//   ar*                    AXI read address channel (master side)
//   rid/rdata/rresp/rlast/rvalid/rready   AXI read data channel
//   err                    sticky protocol/response error
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BEATS = 4
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic [1:0]        rd_req,
    input  logic [2:0]        rd_type0,
    input  logic [2:0]        rd_type1,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [1:0]        rd_rdy,
    output logic [1:0]        ret_valid,
    output logic [1:0]        ret_last,
    output logic [DATA_W-1:0] ret_data,

    input  logic              wr_pending,
    input  logic [ADDR_W-1:0] wr_addr,

    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,

    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,

    output logic              err
);

    localparam int         CNT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [7:0] LINE_LEN  = 8'(LINE_BEATS - 1);
    localparam logic [2:0] TYPE_BYTE = 3'b000;
    localparam logic [2:0] TYPE_HALF = 3'b001;
    localparam logic [2:0] TYPE_LINE = 3'b100;

    typedef enum logic {
        AR_IDLE  = 1'b0,
        AR_VALID = 1'b1
    } ar_state_t;

    ar_state_t          r_state;
    logic               r_arvalid;
    logic [ADDR_W-1:0]  r_araddr;
    logic [3:0]         r_arid;
    logic [7:0]         r_arlen;
    logic [2:0]         r_arsize;

    logic [1:0]         r_busy;
    logic [7:0]         r_exp_len [2];
    logic [CNT_W-1:0]   r_cnt     [2];
    logic               r_err;

    logic [1:0]         w_blk;
    logic [1:0]         w_elig;
    logic               w_win;
    logic               w_grant_any;
    logic [1:0]         w_grant;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [2:0]         w_sel_type;
    logic [7:0]         w_sel_len;
    logic [2:0]         w_sel_size;

    logic               w_rport;
    logic               w_rbusy;
    logic               w_beat_acc;
    logic [7:0]         w_rcnt_ext;
    logic [7:0]         w_rexp_len;
    logic               w_err_set;
    logic               w_unused;

    // RAW hazard: compare word addresses only, a pending write to any byte of
    // the same word must be visible before the read is issued.
    assign w_blk[0] = wr_pending & (rd_addr0[ADDR_W-1:2] == wr_addr[ADDR_W-1:2]);
    assign w_blk[1] = wr_pending & (rd_addr1[ADDR_W-1:2] == wr_addr[ADDR_W-1:2]);
    assign w_elig   = rd_req & ~r_busy & ~w_blk;

`ifdef RD_ARB_RR_EN
    logic r_last_grant;

    // On contention the port that did not win last time takes the grant.
    assign w_win = (&w_elig) ? ~r_last_grant : w_elig[1];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_last_grant <= 1'b0;
        end else if (w_grant_any) begin
            r_last_grant <= w_win;
        end
    end
`else
    // Fixed priority: port 1 wins whenever it is eligible.
    assign w_win = w_elig[1];
`endif

    // Grants are only offered while no AR is waiting on arready, and never
    // while reset is held so rd_rdy reads 0 during reset.
    assign w_grant_any = (r_state == AR_IDLE) & (|w_elig) & ~areset;
    assign w_grant     = w_grant_any ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    assign rd_rdy      = w_grant;

    always_comb begin
        w_sel_addr = w_win ? rd_addr1 : rd_addr0;
        w_sel_type = w_win ? rd_type1 : rd_type0;
        w_sel_len  = (w_sel_type == TYPE_LINE) ? LINE_LEN : 8'd0;
        case (w_sel_type)
            TYPE_BYTE: w_sel_size = 3'b000;
            TYPE_HALF: w_sel_size = 3'b001;
            default:   w_sel_size = 3'b010;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= AR_IDLE;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arid    <= 4'd0;
            r_arlen   <= 8'd0;
            r_arsize  <= 3'b010;
        end else begin
            case (r_state)
                AR_IDLE: begin
                    if (w_grant_any) begin
                        r_araddr  <= w_sel_addr;
                        r_arid    <= {3'b000, w_win};
                        r_arlen   <= w_sel_len;
                        r_arsize  <= w_sel_size;
                        r_arvalid <= 1'b1;
                        r_state   <= AR_VALID;
                    end
                end
                AR_VALID: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= AR_IDLE;
                    end
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_state   <= AR_IDLE;
                end
            endcase
        end
    end

    assign arvalid = r_arvalid;
    assign araddr  = r_araddr;
    assign arid    = r_arid;
    assign arlen   = r_arlen;
    assign arsize  = r_arsize;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    // R channel: only ids that belong to a busy port are accepted; beats for
    // an idle port are left un-acked and flagged as an error.
    assign w_rport    = rid[0];
    assign w_rbusy    = r_busy[w_rport];
    assign rready     = w_rbusy;
    assign w_beat_acc = rvalid & w_rbusy;
    assign ret_valid  = {w_beat_acc & w_rport, w_beat_acc & ~w_rport};
    assign ret_last   = ret_valid & {2{rlast}};
    assign ret_data   = rdata;

    assign w_rcnt_ext = 8'(r_cnt[w_rport]);
    assign w_rexp_len = r_exp_len[w_rport];
    assign w_err_set  = (rvalid & ~w_rbusy)
                      | (w_beat_acc & (rresp != 2'b00))
                      | (w_beat_acc & rlast  & (w_rcnt_ext != w_rexp_len))
                      | (w_beat_acc & ~rlast & (w_rcnt_ext == w_rexp_len));

    // A grant and an accepted beat never hit the same port in one cycle:
    // a grant needs the port idle, an accepted beat needs it busy.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_busy <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_exp_len[i] <= 8'd0;
                r_cnt[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_grant[i]) begin
                    r_busy[i]    <= 1'b1;
                    r_exp_len[i] <= w_sel_len;
                    r_cnt[i]     <= '0;
                end else if (ret_valid[i]) begin
                    if (rlast) begin
                        r_busy[i] <= 1'b0;
                        r_cnt[i]  <= '0;
                    end else begin
                        r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    // Upper id bits and the byte offset of the write address carry no meaning here.
    assign w_unused = &{1'b0, rid[3:1], wr_addr[1:0]};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Directed bench for axi_rd_arbiter. A transaction-level model tracks which
// port has a read outstanding, how many beats it expects and has seen, and
// the AR request waiting for arready; a negedge process compares every DUT
// output against it each cycle. Directed sequences add literal checks.
// Works with and without RD_ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_BEATS = 4;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [1:0]        rd_req = 2'b00;
    logic [2:0]        rd_type0 = 3'b010;
    logic [2:0]        rd_type1 = 3'b010;
    logic [ADDR_W-1:0] rd_addr0 = '0;
    logic [ADDR_W-1:0] rd_addr1 = '0;
    logic [1:0]        rd_rdy;
    logic [1:0]        ret_valid;
    logic [1:0]        ret_last;
    logic [DATA_W-1:0] ret_data;
    logic              wr_pending = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready = 1'b0;
    logic [3:0]        rid = 4'd0;
    logic [DATA_W-1:0] rdata = '0;
    logic [1:0]        rresp = 2'b00;
    logic              rlast = 1'b0;
    logic              rvalid = 1'b0;
    logic              rready;
    logic              err;

    always #5 aclk = ~aclk;

    axi_rd_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BEATS(LINE_BEATS)
    ) dut (
        .aclk(aclk), .areset(areset),
        .rd_req(rd_req), .rd_type0(rd_type0), .rd_type1(rd_type1),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_pending(wr_pending), .wr_addr(wr_addr),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .err(err)
    );

    int   testsRun    = 0;
    int   testsFailed = 0;
    logic checkEn     = 1'b0;

    // Transaction-level model state
    logic              mBusy [2];
    int                mLen  [2];
    int                mSeen [2];
    logic              mErr;
    logic              mArValid;
    logic [ADDR_W-1:0] mArAddr;
    logic [3:0]        mArId;
    logic [7:0]        mArLen;
    logic [2:0]        mArSize;
    logic              mLastGrant;
    int                grantLog [$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic portEligible(int p);
        logic [ADDR_W-1:0] a;
        logic              blocked;
        a       = (p == 1) ? rd_addr1 : rd_addr0;
        blocked = wr_pending && ((a >> 2) == (wr_addr >> 2));
        return rd_req[p] && !mBusy[p] && !blocked;
    endfunction

    function automatic logic [1:0] expectedGrant();
        logic e0, e1;
        int   winner;
        if (areset || mArValid) return 2'b00;
        e0 = portEligible(0);
        e1 = portEligible(1);
        if (e0 && e1) begin
`ifdef RD_ARB_RR_EN
            winner = mLastGrant ? 0 : 1;
`else
            winner = 1;
`endif
            return (winner == 1) ? 2'b10 : 2'b01;
        end
        if (e1) return 2'b10;
        if (e0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [2:0] sizeOf(logic [2:0] t);
        if (t == 3'b000) return 3'b000;
        if (t == 3'b001) return 3'b001;
        return 3'b010;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 2; i++) begin
            mBusy[i] = 1'b0;
            mLen[i]  = 0;
            mSeen[i] = 0;
        end
        mErr       = 1'b0;
        mArValid   = 1'b0;
        mArAddr    = '0;
        mArId      = 4'd0;
        mArLen     = 8'd0;
        mArSize    = 3'b010;
        mLastGrant = 1'b0;
    endtask

    // Model step: one AXI cycle of bookkeeping from the sampled inputs.
    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            resetModel();
        end else begin : modelStep
            logic [1:0] g;
            int         p;
            logic [2:0] t;
            g = expectedGrant();
            if (rvalid) begin
                p = int'(rid[0]);
                if (!mBusy[p]) begin
                    mErr = 1'b1;
                end else begin
                    if (rresp != 2'b00) mErr = 1'b1;
                    if (rlast) begin
                        if (mSeen[p] != mLen[p]) mErr = 1'b1;
                        mBusy[p] = 1'b0;
                        mSeen[p] = 0;
                    end else begin
                        if (mSeen[p] == mLen[p]) mErr = 1'b1;
                        mSeen[p]++;
                    end
                end
            end
            if (mArValid && arready) mArValid = 1'b0;
            if (g != 2'b00) begin
                p          = g[1] ? 1 : 0;
                t          = (p == 1) ? rd_type1 : rd_type0;
                mArValid   = 1'b1;
                mArAddr    = (p == 1) ? rd_addr1 : rd_addr0;
                mArId      = 4'(p);
                mArLen     = (t == 3'b100) ? 8'(LINE_BEATS - 1) : 8'd0;
                mArSize    = sizeOf(t);
                mBusy[p]   = 1'b1;
                mLen[p]    = int'(mArLen);
                mSeen[p]   = 0;
                mLastGrant = g[1];
                grantLog.push_back(p);
            end
        end
    end

    // Compare process: every output against the model, away from the edge.
    always @(negedge aclk) begin
        if (checkEn) begin : cmp
            logic       expRready;
            logic [1:0] expRetValid;
            expRready   = mBusy[int'(rid[0])];
            expRetValid = {rvalid && expRready && rid[0], rvalid && expRready && !rid[0]};
            checkOutput("rd_rdy", 64'(rd_rdy), 64'(expectedGrant()));
            checkOutput("rready", 64'(rready), 64'(expRready));
            checkOutput("ret_valid", 64'(ret_valid), 64'(expRetValid));
            checkOutput("ret_last", 64'(ret_last), 64'(rlast ? expRetValid : 2'b00));
            if (expRetValid != 2'b00) checkOutput("ret_data", 64'(ret_data), 64'(rdata));
            checkOutput("arvalid", 64'(arvalid), 64'(mArValid));
            if (mArValid) begin
                checkOutput("araddr", 64'(araddr), 64'(mArAddr));
                checkOutput("arid", 64'(arid), 64'(mArId));
                checkOutput("arlen", 64'(arlen), 64'(mArLen));
                checkOutput("arsize", 64'(arsize), 64'(mArSize));
            end
            checkOutput("ar_const", 64'({arburst, arlock, arcache, arprot}), 64'({2'b01, 2'b00, 4'b0000, 3'b000}));
            checkOutput("err", 64'(err), 64'(mErr));
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [2:0] t0, input logic [31:0] a0,
                                 input logic [2:0] t1, input logic [31:0] a1);
        rd_req   = req;
        rd_type0 = t0;
        rd_addr0 = a0;
        rd_type1 = t1;
        rd_addr1 = a1;
    endtask

    task automatic arHandshake();
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    task automatic sendBeat(input logic p, input logic [31:0] d, input logic last,
                            input logic [1:0] resp, input logic [1:0] expValid);
        rvalid = 1'b1;
        rid    = {3'b000, p};
        rdata  = d;
        rlast  = last;
        rresp  = resp;
        settle();
        checkOutput("beat_ret_valid", 64'(ret_valid), 64'(expValid));
        checkOutput("beat_ret_last", 64'(ret_last), 64'(last ? expValid : 2'b00));
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic doReset();
        areset = 1'b1;
        applyStimulus(2'b00, 3'b010, 32'h0, 3'b010, 32'h0);
        wr_pending = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        rid        = 4'd0;
        tick();
        tick();
        areset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] expRdy;
        logic       winner;

        // ---- reset state, with requests already pending ----
        applyStimulus(2'b11, 3'b010, 32'h40, 3'b010, 32'h80);
        tick();
        checkEn = 1'b1;
        settle();
        checkOutput("rst_rd_rdy", 64'(rd_rdy), 64'(2'b00));
        checkOutput("rst_arvalid", 64'(arvalid), 64'(1'b0));
        checkOutput("rst_araddr", 64'(araddr), 64'(32'h0));
        checkOutput("rst_arid", 64'(arid), 64'(4'd0));
        checkOutput("rst_arlen", 64'(arlen), 64'(8'd0));
        checkOutput("rst_arsize", 64'(arsize), 64'(3'b010));
        checkOutput("rst_err", 64'(err), 64'(1'b0));
        doReset();

        // ---- single icache line read ----
        applyStimulus(2'b01, 3'b100, 32'h1C00_0000, 3'b010, 32'h0);
        settle();
        checkOutput("line_rd_rdy", 64'(rd_rdy), 64'(2'b01));
        checkOutput("line_arvalid_pre", 64'(arvalid), 64'(1'b0));
        tick();
        rd_req = 2'b00;
        settle();
        checkOutput("line_arvalid", 64'(arvalid), 64'(1'b1));
        checkOutput("line_arid", 64'(arid), 64'(4'd0));
        checkOutput("line_arlen", 64'(arlen), 64'(8'd3));
        checkOutput("line_arsize", 64'(arsize), 64'(3'b010));
        checkOutput("line_araddr", 64'(araddr), 64'(32'h1C00_0000));
        arHandshake();
        settle();
        checkOutput("line_arvalid_done", 64'(arvalid), 64'(1'b0));
        for (int k = 0; k < 4; k++) sendBeat(1'b0, 32'hA000_0000 + 32'(k), (k == 3), 2'b00, 2'b01);
        settle();
        checkOutput("line_busy_clear", 64'(rready), 64'(1'b0));
        checkOutput("line_err", 64'(err), 64'(1'b0));

        // ---- simultaneous requests: port 1 word, port 0 line ----
        applyStimulus(2'b11, 3'b100, 32'h200, 3'b010, 32'h100);
        settle();
        checkOutput("sim_rdy_first", 64'(rd_rdy), 64'(2'b10));
        tick();
        settle();
        checkOutput("sim_rdy_arv", 64'(rd_rdy), 64'(2'b00));
        checkOutput("sim_arid1", 64'(arid), 64'(4'd1));
        checkOutput("sim_arlen1", 64'(arlen), 64'(8'd0));
        checkOutput("sim_araddr1", 64'(araddr), 64'(32'h100));
        arHandshake();
        settle();
        checkOutput("sim_rdy_second", 64'(rd_rdy), 64'(2'b01));
        tick();
        rd_req = 2'b00;
        settle();
        checkOutput("sim_arid0", 64'(arid), 64'(4'd0));
        checkOutput("sim_arlen0", 64'(arlen), 64'(8'd3));
        checkOutput("sim_araddr0", 64'(araddr), 64'(32'h200));
        arHandshake();
        for (int k = 0; k < 4; k++) sendBeat(1'b0, 32'hB000_0000 + 32'(k), (k == 3), 2'b00, 2'b01);
        sendBeat(1'b1, 32'hC0DE_0001, 1'b1, 2'b00, 2'b10);

        // ---- RAW hazard block ----
        wr_pending = 1'b1;
        wr_addr    = 32'h300;
        applyStimulus(2'b11, 3'b010, 32'h400, 3'b010, 32'h300);
        settle();
        checkOutput("raw_rdy_p0", 64'(rd_rdy), 64'(2'b01));
        tick();
        rd_req = 2'b10;
        arHandshake();
        settle();
        checkOutput("raw_blocked", 64'(rd_rdy), 64'(2'b00));
        wr_pending = 1'b0;
        settle();
        checkOutput("raw_released", 64'(rd_rdy), 64'(2'b10));
        tick();
        rd_req = 2'b00;
        arHandshake();
        sendBeat(1'b0, 32'h0000_0400, 1'b1, 2'b00, 2'b01);
        sendBeat(1'b1, 32'h0000_0300, 1'b1, 2'b00, 2'b10);

        // ---- arready held low for 5 cycles ----
        applyStimulus(2'b01, 3'b001, 32'h502, 3'b010, 32'h600);
        settle();
        checkOutput("hold_rdy", 64'(rd_rdy), 64'(2'b01));
        tick();
        rd_req = 2'b11;
        for (int k = 0; k < 5; k++) begin
            settle();
            checkOutput("hold_arvalid", 64'(arvalid), 64'(1'b1));
            checkOutput("hold_araddr", 64'(araddr), 64'(32'h502));
            checkOutput("hold_arsize", 64'(arsize), 64'(3'b001));
            checkOutput("hold_no_rdy", 64'(rd_rdy), 64'(2'b00));
            tick();
        end
        rd_req = 2'b10;
        arHandshake();
        settle();
        checkOutput("hold_next_rdy", 64'(rd_rdy), 64'(2'b10));
        tick();
        rd_req = 2'b00;
        arHandshake();
        sendBeat(1'b1, 32'h0000_0600, 1'b1, 2'b00, 2'b10);
        sendBeat(1'b0, 32'h0000_0500, 1'b1, 2'b00, 2'b01);
        settle();
        checkOutput("clean_err", 64'(err), 64'(1'b0));

        // ---- error: rresp on beat 2, sticky ----
        doReset();
        applyStimulus(2'b01, 3'b100, 32'h1000, 3'b010, 32'h0);
        tick();
        rd_req = 2'b00;
        arHandshake();
        sendBeat(1'b0, 32'h1, 1'b0, 2'b00, 2'b01);
        settle();
        checkOutput("resp_err_before", 64'(err), 64'(1'b0));
        sendBeat(1'b0, 32'h2, 1'b0, 2'b10, 2'b01);
        settle();
        checkOutput("resp_err_set", 64'(err), 64'(1'b1));
        sendBeat(1'b0, 32'h3, 1'b0, 2'b00, 2'b01);
        sendBeat(1'b0, 32'h4, 1'b1, 2'b00, 2'b01);
        repeat (3) tick();
        checkOutput("resp_err_sticky", 64'(err), 64'(1'b1));

        // ---- error: early rlast on a line read ----
        doReset();
        applyStimulus(2'b10, 3'b010, 32'h0, 3'b100, 32'h2000);
        settle();
        checkOutput("early_rdy", 64'(rd_rdy), 64'(2'b10));
        tick();
        rd_req = 2'b00;
        arHandshake();
        sendBeat(1'b1, 32'h11, 1'b0, 2'b00, 2'b10);
        sendBeat(1'b1, 32'h12, 1'b0, 2'b00, 2'b10);
        settle();
        checkOutput("early_err_before", 64'(err), 64'(1'b0));
        sendBeat(1'b1, 32'h13, 1'b1, 2'b00, 2'b10);
        settle();
        checkOutput("early_err_set", 64'(err), 64'(1'b1));
        checkOutput("early_busy_clear", 64'(rready), 64'(1'b0));

        // ---- error: beat for an idle port ----
        doReset();
        rvalid = 1'b1;
        rid    = 4'd1;
        rdata  = 32'hDEAD_BEEF;
        rlast  = 1'b1;
        settle();
        checkOutput("idle_rready", 64'(rready), 64'(1'b0));
        checkOutput("idle_ret_valid", 64'(ret_valid), 64'(2'b00));
        checkOutput("idle_err_before", 64'(err), 64'(1'b0));
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        settle();
        checkOutput("idle_err_set", 64'(err), 64'(1'b1));

        // ---- reset in the middle of a line read ----
        doReset();
        applyStimulus(2'b01, 3'b100, 32'h3000, 3'b010, 32'h0);
        tick();
        rd_req = 2'b00;
        arHandshake();
        sendBeat(1'b0, 32'h21, 1'b0, 2'b00, 2'b01);
        areset = 1'b1;
        settle();
        checkOutput("midrst_rready", 64'(rready), 64'(1'b0));
        checkOutput("midrst_err", 64'(err), 64'(1'b0));
        tick();
        areset = 1'b0;
        sendBeat(1'b0, 32'h22, 1'b0, 2'b00, 2'b00);
        settle();
        checkOutput("midrst_stray_err", 64'(err), 64'(1'b1));

        // ---- continuous contention with word reads ----
        doReset();
        grantLog.delete();
        applyStimulus(2'b11, 3'b010, 32'h700, 3'b010, 32'h800);
        for (int r = 0; r < 4; r++) begin
`ifdef RD_ARB_RR_EN
            expRdy = (r % 2 == 0) ? 2'b10 : 2'b01;
`else
            expRdy = 2'b10;
`endif
            settle();
            checkOutput("contend_rdy", 64'(rd_rdy), 64'(expRdy));
            tick();
            winner  = expRdy[1];
            arready = 1'b1;
            rvalid  = 1'b1;
            rid     = {3'b000, winner};
            rlast   = 1'b1;
            rdata   = 32'(r);
            tick();
            arready = 1'b0;
            rvalid  = 1'b0;
            rlast   = 1'b0;
        end
        rd_req = 2'b00;
        checkOutput("contend_log_size", 64'(grantLog.size()), 64'(4));
        for (int r = 0; r < 4 && r < grantLog.size(); r++) begin
`ifdef RD_ARB_RR_EN
            checkOutput("contend_log", 64'(grantLog[r]), 64'((r % 2 == 0) ? 1 : 0));
`else
            checkOutput("contend_log", 64'(grantLog[r]), 64'(1));
`endif
        end
        settle();
        checkOutput("contend_err", 64'(err), 64'(1'b0));
        tick();

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read address/data channel pair between two cache-style read requesters: port 0 = icache refill, port 1 = dcache refill/uncached load.
- Latches one AR request at a time and tags it with arid = port index.
- Routes R beats back by rid and tracks per-port outstanding state.
- Blocks reads whose address matches an in-flight write (RAW hazard against the write path).
- Sits between the cache/SRAM-side request logic and the AXI interconnect inside the CPU top.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, R data width; fixed at 32 for this core.
- LINE_BEATS, 4, beats per line refill; arlen = LINE_BEATS-1 for line reads.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- rd_req[1:0]  in  2  per-port read request.
- rd_type0/rd_type1  in  3 each  3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 line.
- rd_addr0/rd_addr1  in  ADDR_W each  request address.
- rd_rdy[1:0]  out  2  request accepted this cycle when rd_req & rd_rdy.
- ret_valid[1:0]  out  2  return beat valid for port.
- ret_last[1:0]  out  2  final beat of the port's transaction.
- ret_data  out  DATA_W  shared return data; qualified by ret_valid.
- wr_pending  in  1  write path has an un-acked write (B not yet received).
- wr_addr  in  ADDR_W  address of the pending write.
- arid  out  4  {3'b0, port}.
- araddr  out  ADDR_W  latched address.
- arlen  out  8  line ? LINE_BEATS-1 : 0.
- arsize  out  3  line/word 3'b010, half 3'b001, byte 3'b000.
- arburst  out  2  constant 2'b01.
- arlock, arcache, arprot  out  2/4/3  constant 0.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  R id.
- rdata  in  DATA_W  R data.
- rresp  in  2  R response.
- rlast  in  1  R last.
- rvalid  in  1  R valid.
- rready  out  1  R ready.
- err  out  1  sticky protocol/response error.

Behaviour:
- Reset (async, areset=1): AR FSM=IDLE; arvalid=0; araddr=0; arid=0; arlen=0; arsize=3'b010; busy[1:0]=0; beat counters=0; err=0; rd_rdy=0.
- AR FSM has 2 states.
  - IDLE: a port is eligible when rd_req[i] & ~busy[i] & ~blk[i], with blk[i] = wr_pending & (rd_addr_i[ADDR_W-1:2] == wr_addr[ADDR_W-1:2]).
  - IDLE: the winner gets rd_rdy[i]=1 combinationally; only the winner's rd_rdy is asserted.
  - IDLE: on handshake, latch araddr, arid, arlen, arsize; set busy[i]; set exp_len[i]=arlen; go to ARV.
  - ARV: arvalid=1, held stable until arready; on arvalid&arready go to IDLE.
  - ARV: rd_rdy=0 for both ports while in ARV.
- Arbitration: fixed, port 1 beats port 0 when both are eligible. A blocked or busy port does not stall the other port.
- Latency: request accepted in cycle N; arvalid first asserted in N+1; a new grant is possible in the cycle after the AR handshake.
- Maximum of 2 transactions in flight (one per port). Out-of-order return between ports is allowed.
- R path:
  - rready = busy[rid[0]] (combinational).
  - ret_valid[i] = rvalid & rready & (rid[0]==i).
  - ret_data = rdata, passed through with 0 latency.
  - ret_last[i] = ret_valid[i] & rlast.
- Per-port beat counter (2 bits for LINE_BEATS=4) increments on each accepted beat and clears on rlast.
- On an accepted beat with rlast: clear busy[i]. A same-cycle new grant to the same port is not allowed, because busy is cleared at the clock edge.
- Simultaneous AR handshake on one port and rlast on the other are independent; both take effect.
- err is set, and stays set until reset, on any of:
  - rresp != 0 on an accepted beat;
  - rlast with beat count != exp_len[i];
  - count == exp_len[i] without rlast;
  - rvalid with rid[0] port not busy (beat is still not accepted: rready=0).
- Reset mid-transaction: all state clears immediately. R beats still arriving afterwards see rready=0 and set err only if rvalid is sampled after reset release.

Optional Feature:
- Macro RD_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_grant register (reset 0) toggles to the port granted; on contention the port != last_grant wins.
- Undefined: fixed port-1 priority as above; no last_grant register.

Test Plan:
- Single icache line read at 0x1C00_0000:
  - arid=0, arlen=3, arsize=2, arvalid asserted the cycle after rd_rdy[0].
  - 4 R beats with rid=0 give ret_valid[0] x4; ret_last[0] on beat 4; busy[0] clears.
- Simultaneous rd_req=2'b11 (word 0x100, line 0x200):
  - port 1 granted first (arid=1, arlen=0); port 0 granted right after the AR handshake.
  - returns rid=0 first, then rid=1, are routed correctly.
- RAW block: wr_pending=1, wr_addr=0x300, port1 requests 0x300 → rd_rdy[1]=0 while port0 at 0x400 is granted; dropping wr_pending → port1 granted the next cycle.
- arready held low 5 cycles: arvalid and araddr are stable throughout; no new rd_rdy.
- Error cases:
  - rresp=2'b10 on beat 2 → err=1, sticky.
  - line read returning rlast on beat 3 → err=1.
  - rvalid with rid=1 while port 1 is idle → rready=0, err=1.
- RD_ARB_RR_EN: continuous rd_req=2'b11 with word reads → grants alternate 1,0,1,0; without the macro → port 1 is granted every time it is eligible.
